req_gnt_checker: RTL and testbench

//  Synthesisable multi-channel request/grant protocol monitor, NUM_CH independent channels.
//  Per-channel FSM checks grant latency window, single-cycle grant, quiet cycle after grant.

---
 rtl/req_gnt_checker.sv | 171 +++++++++++++++++
 tb/tb_req_gnt_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/req_gnt_checker.sv
// Passive multi-channel request/grant protocol monitor: per-channel latency/quiet
// FSMs, cross-channel grant exclusivity, sticky flags and a saturating violation count.
module req_gnt_checker #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MIN_LAT    = 1,
  parameter int unsigned MAX_LAT    = 1,
  parameter int unsigned ONEHOT_GNT = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_ip,
  input  logic              reset_ip,
  input  logic              clr_ip,
  input  logic [NUM_CH-1:0] req_ip,
  input  logic [NUM_CH-1:0] gnt_ip,
  output logic [NUM_CH-1:0] pend_op,
  output logic              err_valid_op,
  output logic [2:0]        err_code_op,
  output logic [CH_W-1:0]   err_ch_op,
  output logic [NUM_CH-1:0] err_flags_op,
  output logic [CNT_W-1:0]  err_cnt_op
);

  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

  localparam logic [2:0] C_EARLY = 3'd1;
  localparam logic [2:0] C_TOUT  = 3'd2;
  localparam logic [2:0] C_BUSY  = 3'd3;
  localparam logic [2:0] C_SPUR  = 3'd4;
  localparam logic [2:0] C_NQUIET = 3'd5;
  localparam logic [2:0] C_MULTI = 3'd6;

  localparam logic [LAT_W-1:0] LAT_MIN = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, QUIET} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [LAT_W-1:0]  lat_q   [NUM_CH];
  logic [LAT_W-1:0]  lat_d   [NUM_CH];
  logic [2:0]        ch_code [NUM_CH];
  logic [NUM_CH-1:0] viol;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] flag_set;
  logic              multi;
  logic              any_viol;
  logic              found;
  logic [2:0]        rep_code;
  logic [CH_W-1:0]   rep_ch;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_d;

  // Per-channel next state, latency count and lowest-numbered violation code
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      viol[i]    = 1'b0;
      ch_code[i] = 3'd0;
      case (state_q[i])
        IDLE: begin
          if (req_ip[i]) begin
            state_d[i] = WAIT;
            lat_d[i]   = LAT_W'(1);
          end
          if (gnt_ip[i]) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_SPUR;
          end
        end
        WAIT: begin
          if (gnt_ip[i]) begin
            state_d[i] = QUIET;
            lat_d[i]   = '0;
          end else if (lat_q[i] == LAT_MAX) begin
            state_d[i] = IDLE;
            lat_d[i]   = '0;
          end else begin
            lat_d[i] = lat_q[i] + LAT_W'(1);
          end
          if (gnt_ip[i] && (lat_q[i] < LAT_MIN)) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_EARLY;
          end else if (!gnt_ip[i] && (lat_q[i] == LAT_MAX)) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_TOUT;
          end else if (req_ip[i]) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_BUSY;
          end
        end
        QUIET: begin
          // A request here is a violation, not the start of a new transaction
          state_d[i] = IDLE;
          if (req_ip[i]) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_BUSY;
          end else if (gnt_ip[i]) begin
            viol[i]    = 1'b1;
            ch_code[i] = C_NQUIET;
          end
        end
        default: begin
          state_d[i] = IDLE;
          lat_d[i]   = '0;
        end
      endcase
      pend_d[i] = (state_d[i] == WAIT);
    end
  end

  // Report selection: multi-grant first, else lowest violating channel
  always_comb begin
    multi    = (ONEHOT_GNT != 0) && ((gnt_ip & (gnt_ip - NUM_CH'(1))) != '0);
    flag_set = viol | (multi ? gnt_ip : '0);
    any_viol = multi || (viol != '0);
    found    = 1'b0;
    rep_code = 3'd0;
    rep_ch   = '0;
    if (multi) begin
      rep_code = C_MULTI;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (viol[i] && !found) begin
          found    = 1'b1;
          rep_code = ch_code[i];
          rep_ch   = CH_W'(i);
        end
      end
    end
    cnt_base = clr_ip ? '0 : err_cnt_op;
    cnt_d    = (any_viol && (cnt_base != CNT_SAT)) ? cnt_base + CNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
    end
  end

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      pend_op      <= '0;
      err_valid_op <= 1'b0;
      err_code_op  <= 3'd0;
      err_ch_op    <= '0;
      err_flags_op <= '0;
      err_cnt_op   <= '0;
    end else begin
      pend_op      <= pend_d;
      err_valid_op <= any_viol;
      if (any_viol) begin
        err_code_op <= rep_code;
        err_ch_op   <= rep_ch;
      end
      err_flags_op <= (clr_ip ? '0 : err_flags_op) | flag_set;
      err_cnt_op   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_req_gnt_checker.sv
// Directed bench for req_gnt_checker: main instance (MIN_LAT=2, MAX_LAT=5) plus a
// CNT_W=2 instance for counter saturation.
module tb_req_gnt_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, clr_b;
  logic [3:0] req, gnt, req_b, gnt_b;
  logic [3:0] pend, pend_b, flags, flags_b;
  logic       err_valid, err_valid_b;
  logic [2:0] err_code, err_code_b;
  logic [1:0] err_ch, err_ch_b;
  logic [15:0] cnt;
  logic [1:0] cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_gnt_checker #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(5), .ONEHOT_GNT(1), .CNT_W(16)) dut (
    .clk_ip(clk), .reset_ip(rst), .clr_ip(clr), .req_ip(req), .gnt_ip(gnt),
    .pend_op(pend), .err_valid_op(err_valid), .err_code_op(err_code),
    .err_ch_op(err_ch), .err_flags_op(flags), .err_cnt_op(cnt)
  );

  req_gnt_checker #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(5), .ONEHOT_GNT(1), .CNT_W(2)) dut_b (
    .clk_ip(clk), .reset_ip(rst), .clr_ip(clr_b), .req_ip(req_b), .gnt_ip(gnt_b),
    .pend_op(pend_b), .err_valid_op(err_valid_b), .err_code_op(err_code_b),
    .err_ch_op(err_ch_b), .err_flags_op(flags_b), .err_cnt_op(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs observed 1 time unit after the edge that sampled the current inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; clr_b = 1'b0;
    req = '0; gnt = '0; req_b = '0; gnt_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_valid", 32'(err_valid), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    tick();

    // 1: legal transaction, grant 3 cycles after request
    req[0] = 1'b1; tick();
    chk("t1_pend_a", 32'(pend[0]), 32'h1);
    req[0] = 1'b0; tick();
    chk("t1_pend_b", 32'(pend[0]), 32'h1);
    tick();
    chk("t1_pend_c", 32'(pend[0]), 32'h1);
    gnt[0] = 1'b1; tick();
    chk("t1_valid_a", 32'(err_valid), 32'h0);
    chk("t1_pend_d", 32'(pend[0]), 32'h0);
    gnt[0] = 1'b0; tick();
    chk("t1_valid_b", 32'(err_valid), 32'h0);
    chk("t1_cnt", 32'(cnt), 32'h0);

    // 2: grant one cycle after request -> EARLY_GNT
    req[1] = 1'b1; tick();
    req[1] = 1'b0; gnt[1] = 1'b1; tick();
    chk("t2_valid", 32'(err_valid), 32'h1);
    chk("t2_code", 32'(err_code), 32'h1);
    chk("t2_ch", 32'(err_ch), 32'h1);
    chk("t2_flags", 32'(flags), 32'h2);
    chk("t2_cnt", 32'(cnt), 32'h1);
    gnt[1] = 1'b0; tick();
    chk("t2_pulse", 32'(err_valid), 32'h0);
    chk("t2_hold", 32'(err_code), 32'h1);

    // 3: no grant -> TIMEOUT, then stray grant -> SPURIOUS_GNT
    req[2] = 1'b1; tick();
    req[2] = 1'b0;
    repeat (4) tick();
    chk("t3_pend_a", 32'(pend[2]), 32'h1);
    chk("t3_valid_a", 32'(err_valid), 32'h0);
    tick();
    chk("t3_valid_b", 32'(err_valid), 32'h1);
    chk("t3_code_b", 32'(err_code), 32'h2);
    chk("t3_ch_b", 32'(err_ch), 32'h2);
    chk("t3_pend_b", 32'(pend[2]), 32'h0);
    tick();
    chk("t3_valid_c", 32'(err_valid), 32'h0);
    gnt[2] = 1'b1; tick();
    chk("t3_code_d", 32'(err_code), 32'h4);
    chk("t3_ch_d", 32'(err_ch), 32'h2);
    chk("t3_flags", 32'(flags), 32'h6);
    chk("t3_cnt", 32'(cnt), 32'h3);
    gnt[2] = 1'b0;

    // 4: clear, then two legal grants together -> MULTI_GNT, then held grant
    req[0] = 1'b1; req[3] = 1'b1; clr = 1'b1; tick();
    chk("t4_clr_flags", 32'(flags), 32'h0);
    chk("t4_clr_cnt", 32'(cnt), 32'h0);
    req = '0; clr = 1'b0; tick();
    gnt[0] = 1'b1; gnt[3] = 1'b1; tick();
    chk("t4_valid", 32'(err_valid), 32'h1);
    chk("t4_code", 32'(err_code), 32'h6);
    chk("t4_ch", 32'(err_ch), 32'h0);
    chk("t4_flags", 32'(flags), 32'h9);
    chk("t4_cnt", 32'(cnt), 32'h1);
    gnt[3] = 1'b0; tick();
    chk("t4_nq_code", 32'(err_code), 32'h5);
    chk("t4_nq_ch", 32'(err_ch), 32'h0);
    chk("t4_nq_cnt", 32'(cnt), 32'h2);
    gnt[0] = 1'b0; tick();
    chk("t4_quiet", 32'(err_valid), 32'h0);

    // 5: 2-bit counter saturation, clear coinciding with a violation
    gnt_b[0] = 1'b1;
    tick(); chk("t5_cnt1", 32'(cnt_b), 32'h1);
    tick(); chk("t5_cnt2", 32'(cnt_b), 32'h2);
    tick(); chk("t5_cnt3", 32'(cnt_b), 32'h3);
    tick(); chk("t5_cnt4", 32'(cnt_b), 32'h3);
    tick(); chk("t5_cnt5", 32'(cnt_b), 32'h3);
    chk("t5_code", 32'(err_code_b), 32'h4);
    clr_b = 1'b1; tick();
    chk("t5_clr_cnt", 32'(cnt_b), 32'h1);
    chk("t5_clr_flags", 32'(flags_b), 32'h1);
    gnt_b[0] = 1'b0; tick();
    chk("t5_clr_only", 32'(cnt_b), 32'h0);
    clr_b = 1'b0;

    // 6: async reset while a request is pending
    req[1] = 1'b1; tick();
    req[1] = 1'b0; tick();
    chk("t6_pend", 32'(pend[1]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_pend", 32'(pend), 32'h0);
    chk("t6_rst_flags", 32'(flags), 32'h0);
    chk("t6_rst_cnt", 32'(cnt), 32'h0);
    chk("t6_rst_code", 32'(err_code), 32'h0);
    tick();
    rst = 1'b0;
    repeat (7) begin
      tick();
      chk("t6_no_tout", 32'(err_valid), 32'h0);
    end
    chk("t6_cnt", 32'(cnt), 32'h0);
    req[1] = 1'b1; tick();
    chk("t6_new_pend", 32'(pend[1]), 32'h1);
    req[1] = 1'b0; gnt[1] = 1'b1; tick();
    chk("t6_new_valid", 32'(err_valid), 32'h1);
    chk("t6_new_code", 32'(err_code), 32'h1);
    chk("t6_new_ch", 32'(err_ch), 32'h1);
    gnt[1] = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
